// File: rtl/calc_port_responder.sv
// Tagged arithmetic/shift request responder: two-cycle request framer, FIFO request
// queue and a three-state executor that returns one registered response per request.
module calc_port_responder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              drop_err,
  output logic [TAG_W-1:0]  drop_tag
);

  localparam int unsigned ENTRY_W = 4 + TAG_W + 2 * DATA_W;
  localparam int unsigned PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);

  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHL = 4'b0101;
  localparam logic [3:0] CMD_SHR = 4'b0110;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ALU, S_SHIFT} state_e;

  // Framer
  logic              fr_busy_q, fr_busy_d;
  logic [3:0]        fr_cmd_q, fr_cmd_d;
  logic [TAG_W-1:0]  fr_tag_q, fr_tag_d;
  logic [DATA_W-1:0] fr_op1_q, fr_op1_d;

  // Request queue
  logic [ENTRY_W-1:0] mem_q [QDEPTH];
  logic [ENTRY_W-1:0] mem_d [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Executor
  state_e            state_q, state_d;
  logic [3:0]        ex_cmd_q, ex_cmd_d;
  logic [TAG_W-1:0]  ex_tag_q, ex_tag_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [4:0]        ex_cnt_q, ex_cnt_d;

  // Registered outputs
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              drop_q, drop_d;
  logic [TAG_W-1:0]  drop_tag_q, drop_tag_d;

  logic               push, pop, full;
  logic [ENTRY_W-1:0] head;
  logic [3:0]         h_cmd;
  logic [TAG_W-1:0]   h_tag;
  logic [DATA_W-1:0]  h_op1, h_op2;
  logic [DATA_W:0]    sum;
  logic [DATA_W-1:0]  shifted;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    head    = mem_q[rd_ptr_q];
    h_cmd   = head[ENTRY_W-1 -: 4];
    h_tag   = head[2*DATA_W +: TAG_W];
    h_op1   = head[DATA_W +: DATA_W];
    h_op2   = head[DATA_W-1:0];
    full    = (count_q == CNT_W'(QDEPTH));
    pop     = (state_q == S_IDLE) && (count_q != '0);
    // A same-cycle pop frees the slot the push needs.
    push    = fr_busy_q && (!full || pop);
    sum     = {1'b0, ex_a_q} + {1'b0, ex_b_q};
    shifted = (ex_cmd_q == CMD_SHL) ? (ex_a_q << 1) : (ex_a_q >> 1);
  end

  // Framer: command cycle captures cmd/tag/op1, next cycle supplies op2 and pushes.
  always_comb begin
    fr_busy_d = 1'b0;
    fr_cmd_d  = fr_cmd_q;
    fr_tag_d  = fr_tag_q;
    fr_op1_d  = fr_op1_q;
    if (!fr_busy_q && (req_cmd_in != 4'd0)) begin
      fr_busy_d = 1'b1;
      fr_cmd_d  = req_cmd_in;
      fr_tag_d  = req_tag_in;
      fr_op1_d  = req_data_in;
    end
    drop_d     = fr_busy_q && !push;
    drop_tag_d = (fr_busy_q && !push) ? fr_tag_q : '0;
  end

  // Queue bookkeeping
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {fr_cmd_q, fr_tag_q, fr_op1_q, req_data_in};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Executor: IDLE pops, ALU answers in one cycle, SHIFT steps one bit per cycle.
  always_comb begin
    state_d  = state_q;
    ex_cmd_d = ex_cmd_q;
    ex_tag_d = ex_tag_q;
    ex_a_d   = ex_a_q;
    ex_b_d   = ex_b_q;
    ex_cnt_d = ex_cnt_q;
    resp_d   = RESP_NONE;
    data_d   = '0;
    tag_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          ex_cmd_d = h_cmd;
          ex_tag_d = h_tag;
          ex_a_d   = h_op1;
          ex_b_d   = h_op2;
          ex_cnt_d = h_op2[4:0];
          state_d  = ((h_cmd == CMD_SHL) || (h_cmd == CMD_SHR)) ? S_SHIFT : S_ALU;
        end
      end
      S_ALU: begin
        state_d = S_IDLE;
        tag_d   = ex_tag_q;
        resp_d  = RESP_ERR;
        if (ex_cmd_q == CMD_ADD) begin
          if (!sum[DATA_W]) begin
            resp_d = RESP_OK;
            data_d = sum[DATA_W-1:0];
          end
        end else if (ex_cmd_q == CMD_SUB) begin
          if (ex_a_q >= ex_b_q) begin
            resp_d = RESP_OK;
            data_d = ex_a_q - ex_b_q;
          end
        end
      end
      S_SHIFT: begin
        if (ex_cnt_q <= 5'd1) begin
          state_d = S_IDLE;
          resp_d  = RESP_OK;
          tag_d   = ex_tag_q;
          data_d  = (ex_cnt_q == 5'd0) ? ex_a_q : shifted;
        end else begin
          ex_a_d   = shifted;
          ex_cnt_d = ex_cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      fr_busy_q  <= 1'b0;
      fr_cmd_q   <= '0;
      fr_tag_q   <= '0;
      fr_op1_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      ex_cmd_q   <= '0;
      ex_tag_q   <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_cnt_q   <= '0;
      resp_q     <= RESP_NONE;
      data_q     <= '0;
      tag_q      <= '0;
      drop_q     <= 1'b0;
      drop_tag_q <= '0;
    end else begin
      fr_busy_q  <= fr_busy_d;
      fr_cmd_q   <= fr_cmd_d;
      fr_tag_q   <= fr_tag_d;
      fr_op1_q   <= fr_op1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      ex_cmd_q   <= ex_cmd_d;
      ex_tag_q   <= ex_tag_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_cnt_q   <= ex_cnt_d;
      resp_q     <= resp_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      drop_q     <= drop_d;
      drop_tag_q <= drop_tag_d;
    end
  end

  // Queue payload needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge c_clk) begin
    mem_q <= mem_d;
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign out_tag  = tag_q;
  assign drop_err = drop_q;
  assign drop_tag = drop_tag_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: a timing-level reference model predicts
// each response (value, tag, cycle) and each queue-full drop.
module tb_calc_port_responder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned QDEPTH = 4;

  logic              c_clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        req_cmd_in = '0;
  logic [DATA_W-1:0] req_data_in = '0;
  logic [TAG_W-1:0]  req_tag_in = '0;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              drop_err;
  logic [TAG_W-1:0]  drop_tag;

  calc_port_responder #(.DATA_W(DATA_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .drop_err(drop_err), .drop_tag(drop_tag)
  );

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  typedef struct {
    int               cyc;
    logic [TAG_W-1:0] tag;
  } drop_t;

  exp_t  exp_q[$];
  drop_t drop_q[$];
  int    pend_pops[$];
  int    next_idle = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: a request framed at cycle n is pushed at n+1, popped by an idle
  // executor no earlier than n+2, and answers one cycle after its execution time.
  task automatic model_req(input int n, input logic [3:0] cmd, input logic [TAG_W-1:0] tag,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int p;
    int t;
    int k;
    int dur;
    exp_t e;
    drop_t d;
    logic [DATA_W:0] s;
    p = n + 1;
    while (pend_pops.size() > 0 && pend_pops[0] <= p) void'(pend_pops.pop_front());
    if (pend_pops.size() >= QDEPTH) begin
      d.cyc = n + 2;
      d.tag = tag;
      drop_q.push_back(d);
      return;
    end
    t = (n + 2 > next_idle) ? n + 2 : next_idle;
    k = int'(b[4:0]);
    e.tag  = tag;
    e.resp = 2'b10;
    e.data = '0;
    dur    = 1;
    case (cmd)
      4'b0001: begin
        s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
        if (s <= (DATA_W+1)'({DATA_W{1'b1}})) begin e.resp = 2'b01; e.data = a + b; end
      end
      4'b0010: if (a >= b) begin e.resp = 2'b01; e.data = a - b; end
      4'b0101: begin e.resp = 2'b01; e.data = a << k; dur = (k == 0) ? 1 : k; end
      4'b0110: begin e.resp = 2'b01; e.data = a >> k; dur = (k == 0) ? 1 : k; end
      default: ;
    endcase
    e.cyc = t + 1 + dur;
    next_idle = e.cyc;
    pend_pops.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int n;
    @(negedge c_clk);
    n = cyc;
    req_cmd_in  = cmd;
    req_tag_in  = tag;
    req_data_in = a;
    @(negedge c_clk);
    req_cmd_in  = 4'($urandom_range(1, 15));
    req_tag_in  = TAG_W'($urandom);
    req_data_in = b;
    model_req(n, cmd, tag, a, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge c_clk);
      req_cmd_in  = '0;
      req_tag_in  = TAG_W'($urandom);
      req_data_in = $urandom;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || drop_q.size() > 0) && guard < 3000) begin
      idle(1);
      guard++;
    end
    if (guard >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending resp=%0d drop=%0d, required 0/0", exp_q.size(), drop_q.size());
      exp_q.delete();
      drop_q.delete();
    end
    idle(40);
  endtask

  task automatic check_reset_outputs();
    @(negedge c_clk);
    n_cmp++;
    if (out_resp !== 2'b00 || out_data !== '0 || out_tag !== '0 || drop_err !== 1'b0 || drop_tag !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: resp=%b data=%h tag=%0d drop=%b dtag=%0d, required all 0",
               out_resp, out_data, out_tag, drop_err, drop_tag);
    end
  endtask

  // Monitor: compares every presented response/drop against the scoreboard head.
  exp_t  mon_e;
  drop_t mon_d;
  always @(negedge c_clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL resp_missing: got nothing by cycle %0d, required resp=%b data=%h tag=%0d",
                 mon_e.cyc, mon_e.resp, mon_e.data, mon_e.tag);
      end
      if (out_resp != 2'b00) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: cycle %0d resp=%b data=%h tag=%0d, required none",
                   cyc, out_resp, out_data, out_tag);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.resp != out_resp || mon_e.data != out_data || mon_e.tag != out_tag) begin
            n_bad++;
            $display("FAIL resp: got cyc=%0d resp=%b data=%h tag=%0d, required cyc=%0d resp=%b data=%h tag=%0d",
                     cyc, out_resp, out_data, out_tag, mon_e.cyc, mon_e.resp, mon_e.data, mon_e.tag);
          end
        end
      end else if (out_data != '0 || out_tag != '0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_outputs: cycle %0d data=%h tag=%0d, required 0", cyc, out_data, out_tag);
      end
      while (drop_q.size() > 0 && drop_q[0].cyc < cyc) begin
        mon_d = drop_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL drop_missing: none by cycle %0d, required drop tag=%0d", mon_d.cyc, mon_d.tag);
      end
      if (drop_err) begin
        n_cmp++;
        if (drop_q.size() == 0) begin
          n_bad++;
          $display("FAIL drop_unexpected: cycle %0d tag=%0d, required no drop", cyc, drop_tag);
        end else begin
          mon_d = drop_q.pop_front();
          if (mon_d.cyc != cyc || mon_d.tag != drop_tag) begin
            n_bad++;
            $display("FAIL drop: got cyc=%0d tag=%0d, required cyc=%0d tag=%0d",
                     cyc, drop_tag, mon_d.cyc, mon_d.tag);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]        c;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] r;
    int                k;

    repeat (2) check_reset_outputs();
    @(negedge c_clk);
    reset = 1'b0;

    // Basic add
    issue(4'b0001, 2'd2, 32'd5, 32'd7);
    drain();

    // Overflow, underflow and invalid command, back to back
    issue(4'b0001, 2'd1, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0010, 2'd3, 32'd3, 32'd4);
    issue(4'b1111, 2'd0, 32'd9, 32'd9);
    issue(4'b0010, 2'd2, 32'd10, 32'd10);
    drain();

    // Shift boundaries; upper op2 bits must be ignored
    issue(4'b0101, 2'd1, 32'd1, 32'd31);
    drain();
    issue(4'b0110, 2'd3, 32'h8000_1234, 32'hFFFF_FFE0);
    drain();
    issue(4'b0110, 2'd0, 32'h8000_0000, 32'h0000_0021);
    drain();

    // Long shift fills the queue; the fifth add is dropped
    issue(4'b0101, 2'd0, 32'd1, 32'd31);
    for (int i = 0; i < 5; i++) issue(4'b0001, TAG_W'(i), 32'(i * 100), 32'd1);
    drain();

    // Reset mid-shift with queued adds discards everything
    issue(4'b0101, 2'd2, 32'd3, 32'd31);
    issue(4'b0001, 2'd1, 32'd1, 32'd1);
    issue(4'b0001, 2'd3, 32'd2, 32'd2);
    idle(4);
    @(negedge c_clk);
    reset = 1'b1;
    req_cmd_in = '0;
    exp_q.delete();
    drop_q.delete();
    pend_pops.delete();
    next_idle = 0;
    repeat (3) check_reset_outputs();
    reset = 1'b0;
    issue(4'b0001, 2'd1, 32'd20, 32'd22);
    drain();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: c = 4'b0001;
        1: c = 4'b0010;
        2: c = 4'b0101;
        3: c = 4'b0110;
        default: begin
          c = 4'($urandom_range(3, 15));
          if (c == 4'd5 || c == 4'd6) c = 4'hF;
        end
      endcase
      if (c == 4'b0001 && $urandom_range(0, 1) == 0) a = a >> 1;
      if (c == 4'b0010 && $urandom_range(0, 1) == 0) b = b >> 4;
      if (c == 4'b0101 || c == 4'b0110) begin
        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
        r = $urandom;
        b = {r[DATA_W-1:5], 5'(k)};
      end
      issue(c, TAG_W'($urandom), a, b);
      idle(int'($urandom_range(0, 2)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have the parameter TAG_W, default 2, giving the request tag width.
REQ-003 The block SHALL have the parameter QDEPTH, default 4, giving the request-queue depth in entries.
REQ-004 c_clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 req_cmd_in, input, 4 bits: command; 0000 nop, 0001 add, 0010 sub, 0101 shift-left, 0110 shift-right; any other non-zero value is invalid.
REQ-007 req_data_in, input, DATA_W bits: operand1 in the command cycle, operand2 in the following cycle.
REQ-008 req_tag_in, input, TAG_W bits: request tag, sampled in the command cycle.
REQ-009 out_resp, output, 2 bits: 00 none, 01 success, 10 error (overflow, underflow or invalid command).
REQ-010 out_data, output, DATA_W bits: result; 0 unless out_resp = 01.
REQ-011 out_tag, output, TAG_W bits: tag of the reported request; 0 when out_resp = 00.
REQ-012 drop_err, output, 1 bit: one-cycle pulse when a request is discarded because the queue is full.
REQ-013 drop_tag, output, TAG_W bits: tag of the discarded request, valid while drop_err = 1.

Function
REQ-014 Request framing:
- A non-zero req_cmd_in in cycle N, with the framer idle, opens a request: cmd, tag and operand1 are captured in N.
- req_data_in in N+1 is captured as operand2; req_cmd_in in N+1 is ignored.
REQ-015 Enqueue: at the end of N+1 the framer pushes {cmd, tag, op1, op2} into the FIFO request queue (QDEPTH entries).
REQ-016 Queue full at push:
- The request is discarded.
- drop_err = 1 and drop_tag = tag in cycle N+2.
- The request never produces an out_resp.
REQ-017 A pop in the same cycle as a push to a full queue SHALL free a slot, so the push succeeds.
REQ-018 The executor FSM SHALL have exactly the states IDLE, ALU and SHIFT.
REQ-019 IDLE:
- If the queue is non-empty, pop the head at the cycle end.
- Go to SHIFT for cmd 0101/0110; otherwise go to ALU.
REQ-020 ALU takes one cycle, then returns to IDLE with the response registered:
- add: out_resp 01 and the sum when there is no carry out of DATA_W; on carry, out_resp 10 and out_data 0.
- sub: out_resp 01 and op1-op2 when op1 >= op2 (unsigned); otherwise out_resp 10 and out_data 0.
- invalid command: out_resp 10 and out_data 0.
REQ-021 SHIFT:
- Shifts op1 one bit per cycle, logical, zero fill, for k = op2[4:0] cycles, with a minimum of 1 cycle.
- k = 0 returns op1 unchanged.
- Bits op2[DATA_W-1:5] are ignored.
- Result out_resp 01, then return to IDLE.
REQ-022 Latency: with an empty queue and IDLE executor, command cycle N yields a registered response visible in:
- cycle N+4 for add, sub or invalid;
- cycle N+3+max(k,1) for a shift.
REQ-023 Each response is held on out_resp/out_data/out_tag for exactly one cycle, then the outputs return to 0.
REQ-024 Responses are issued in request order, one per executed request.
REQ-025 Duplicate outstanding tags are not checked; each request is processed independently.
REQ-026 With back-to-back add/sub requests (one every 2 cycles), the queue never exceeds 1 entry.

Reset
REQ-027 While reset = 1, all of the following SHALL hold:
- out_resp = 00, out_data = 0, out_tag = 0, drop_err = 0, drop_tag = 0;
- the queue is empty, the FSM is in IDLE and the framer is idle.
REQ-028 Reset asserted mid-request or mid-shift SHALL discard all captured and queued requests, with no response and no drop_err.
REQ-029 After reset deasserts, the first rising edge may capture a command.

Verification
REQ-030 Add: cmd 0001, tag 2, op1 5, op2 7 in cycles 0/1 -> cycle 4: out_resp 01, out_data 12, out_tag 2; cycle 5: out_resp 00.
REQ-031 Overflow/underflow:
- add FFFFFFFF + 1 -> out_resp 10, out_data 0.
- sub 3 - 4 -> out_resp 10, out_data 0.
- cmd 1111 -> out_resp 10 at N+4.
REQ-032 Shift:
- shl 1 by 31 at cycles 0/1 -> cycle 34: out_resp 01, out_data 80000000.
- shr by 0 -> N+4 with op1 unchanged.
REQ-033 Queue full: shl by 31, then five add requests in consecutive 2-cycle slots ->
- the fifth add sees a full queue: drop_err pulses with its tag;
- the remaining four responses arrive in order after the shift.
REQ-034 Reset mid-shift: assert reset at cycle 10 of a 31-cycle shift with 2 queued adds -> no responses ever issued; a new add after reset responds at N+4.
